// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter: FSM state encoding,
// index-width helper and default sizing.
package uart_arb_pkg;

    localparam int DEF_NUM_REQ       = 4;
    localparam int DEF_START_TIMEOUT = 4;
    localparam int TMO_W             = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    // Index width for n requesters, never narrower than one bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams and the UART transmit handshake, bundled as one bus.
// master = arbiter side, slave = requesters plus UART.
interface uart_tx_arbiter_if import uart_arb_pkg::*; #(
    parameter int NUM_REQ = DEF_NUM_REQ
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           tx_data;
    logic                 transmit;
    logic                 tx_empty;

    modport master (
        input  req_valid, req_data, req_last, tx_empty,
        output req_ready, tx_data, transmit
    );

    modport slave (
        output req_valid, req_data, req_last, tx_empty,
        input  req_ready, tx_data, transmit
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid requester after ptr, or only
// the lock index while a packet is open.
module rr_pick import uart_arb_pkg::*; #(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               lock_en,
    input  logic [IDX_W-1:0]   lock_idx,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        if (lock_en) begin
            if (valid[lock_idx]) begin
                any             = 1'b1;
                idx             = lock_idx;
                grant[lock_idx] = 1'b1;
            end
        end else begin
            // Scan ptr+1 .. ptr+NUM_REQ so the last winner has lowest priority.
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
                if (!any && valid[cand]) begin
                    any         = 1'b1;
                    idx         = cand;
                    grant[cand] = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one byte-wide UART transmitter between NUM_REQ byte sources with
// round-robin arbitration and packet locking; one byte in flight at a time.
module uart_tx_arbiter import uart_arb_pkg::*; #(
    parameter int  NUM_REQ       = DEF_NUM_REQ,
    parameter int  START_TIMEOUT = DEF_START_TIMEOUT,
    localparam int IDX_W         = clog2(NUM_REQ)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    uart_tx_arbiter_if.master    bus,
    output logic [IDX_W-1:0]     grant_id,
    output logic                 locked,
    output logic                 tx_err
);
    state_t             state, state_nxt;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] pick_grant;
    logic               pick_any;
    logic [NUM_REQ-1:0] ready;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               accept;
    logic               timeout;
    logic [7:0]         tx_data_r;
    logic               transmit_r;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .valid    (bus.req_valid),
        .ptr      (ptr),
        .lock_en  (locked),
        .lock_idx (grant_id),
        .grant    (pick_grant),
        .idx      (pick_idx),
        .any      (pick_any)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = '0;
        accept    = 1'b0;
        timeout   = 1'b0;
        case (state)
            ST_IDLE: begin
                // A busy UART (tx_empty low) blocks all grants.
                if (bus.tx_empty && pick_any) begin
                    ready     = pick_grant;
                    accept    = 1'b1;
                    state_nxt = ST_LAUNCH;
                end
            end
            ST_LAUNCH: state_nxt = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (!bus.tx_empty) begin
                    state_nxt = ST_WAIT_DONE;
                end else if (tmo_cnt == TMO_W'(START_TIMEOUT - 1)) begin
                    timeout   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_DONE: if (bus.tx_empty) state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr        <= IDX_W'(NUM_REQ - 1);
            tmo_cnt    <= '0;
            transmit_r <= 1'b0;
            tx_data_r  <= 8'h00;
            grant_id   <= '0;
            locked     <= 1'b0;
        end else begin
            transmit_r <= accept;
            if (state == ST_WAIT_BUSY) tmo_cnt <= tmo_cnt + 1'b1;
            else                       tmo_cnt <= '0;
            if (accept) begin
                tx_data_r <= bus.req_data[int'(pick_idx)*8 +: 8];
                grant_id  <= pick_idx;
                locked    <= !bus.req_last[pick_idx];
                ptr       <= pick_idx;
            end
        end
    end

    assign bus.req_ready = ready;
    assign bus.tx_data   = tx_data_r;
    assign bus.transmit  = transmit_r;
    assign tx_err        = timeout;
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single byte-wide UART transmitter (`uart`, `transmit`/`tx_data`/`tx_empty` interface) between several on-chip byte sources. Round-robin arbitration with packet locking guarantees that multi-byte messages from one source are never interleaved with another's. Sits between the requesters (debug monitor, status reporter, loopback) and the `uart` instance, on the same `clock` domain.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `START_TIMEOUT`, 4: cycles allowed after `transmit` for `tx_empty` to fall, 1..15.
- `clock`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  requester i has a byte on its `req_data` slice.
- `req_data`  in  NUM_REQ*8  byte for requester i at bits [8i+7:8i].
- `req_last`  in  NUM_REQ  byte is the final byte of its packet; sampled with data.
- `req_ready`  out  NUM_REQ  one-hot or zero; byte i accepted on the edge where `req_valid[i] & req_ready[i]`.
- `tx_data`  out  8  byte to the UART; registered.
- `transmit`  out  1  one-cycle start strobe to the UART; registered.
- `tx_empty`  in  1  UART idle flag, high when the shifter is idle.
- `grant_id`  out  clog2(NUM_REQ)  index of the last accepted requester.
- `locked`  out  1  a packet is open; only `grant_id` may be accepted.
- `tx_err`  out  1  one-cycle pulse: UART failed to go busy within `START_TIMEOUT`.

## Operation
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- IDLE: if `tx_empty`=1, pick a requester and assert its `req_ready` combinationally; no pick → all `req_ready` 0. Accept edge: latch byte into `tx_data`, `grant_id` ← i, `locked` ← !`req_last[i]`, advance pointer to i, go LAUNCH.
- Pick rule, unlocked: first `req_valid` scanning from pointer+1 upward, wrapping modulo NUM_REQ. Locked: only `grant_id` eligible; others wait regardless of valid.
- LAUNCH: `transmit`=1 this cycle only; go WAIT_BUSY, timeout counter cleared.
- WAIT_BUSY: `tx_empty`=0 → WAIT_DONE. Counter reaches START_TIMEOUT with `tx_empty` still 1 → `tx_err` pulse, go IDLE (byte dropped, lock state unchanged).
- WAIT_DONE: `tx_empty`=1 → IDLE.
- `req_ready` is 0 in every state except IDLE; at most one byte in flight.
- Lock persists until a `req_last` byte from the locked requester is accepted; no lock timeout.
- Requester deasserting `req_valid` without handshake is legal; nothing is latched.

## Timing
- Reset values: state IDLE, `transmit` 0, `tx_data` 8'h00, `grant_id` 0, `locked` 0, `tx_err` 0; pointer = NUM_REQ-1 so requester 0 wins first.
- Accept edge N → `transmit`=1 and valid `tx_data` during cycle N+1; `tx_data` held stable until the next accept.
- Minimum issue interval: accept, LAUNCH, ≥1 WAIT_BUSY, ≥1 WAIT_DONE, IDLE → next accept no earlier than 4 cycles after the previous; in practice bounded by UART frame length.
- `tx_empty`=0 in IDLE: no accept (UART busy from outside or before reset).
- Reset mid-transfer: arbiter returns to IDLE and lock clears; the UART's frame completes on its own and IDLE waits for `tx_empty`=1 before the next accept.
- Simultaneous valids unlocked: exactly one ready, by rotation; each of N continuously-valid requesters is served once per N bytes.

## Structure
- Package `uart_arb_pkg`: state enum (2-bit), `clog2` helper, default NUM_REQ/START_TIMEOUT constants.
- Sub-module `rr_pick`: combinational round-robin picker (valid vector, pointer, lock enable, lock index → one-hot grant, index, any). Everything else lives in the top module.

## Test plan
- Single byte: req 2 sends 8'hB2 with last=1 → `transmit` one cycle after accept, `tx_data`=8'hB2, `grant_id`=2, `locked`=0.
- Fairness: all 4 valid continuously with last=1 → grant order 0,1,2,3,0; never repeated while others wait.
- Packet lock: req 1 sends 3 bytes (last on third) while req 0 and 3 are valid → bytes 1,1,1 contiguous on `tx_data`; then req 3, then req 0.
- Timeout: UART model holds `tx_empty`=1 after `transmit` → `tx_err` pulses exactly START_TIMEOUT cycles later (4), arbiter back to IDLE and accepts next byte.
- Busy UART: `tx_empty` forced 0 with req 0 valid → `req_ready` stays 0; releases on `tx_empty` rise.
- Reset mid-packet: assert `reset_n` low during locked WAIT_DONE → all outputs at reset values immediately; after release req 2 may win without waiting for the old packet's last.
